// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: instruction-fetch state encoding and
//                the default fetch timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    INC  = 2'd2
  } ifetch_state_t;

  // Default number of REQ cycles before a fetch is declared failed
  localparam int IFETCH_TMO_DEFAULT = 64;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ifetch_tmo.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_tmo
//  Description : 8-bit saturating fetch timeout counter. Cleared when a fetch
//                is accepted, counts every REQ cycle without a response, and
//                flags expiry when the count reaches TMO_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_tmo #(
  parameter int TMO_CYCLES = 64
) (
  input  logic clk_sys,
  input  logic clr,
  input  logic clr_cnt,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TMO_CYCLES - 1);

  logic [7:0] cnt;

  // Saturating counter: never wraps past 8'hFF
  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      cnt <= 8'd0;
    end else if (clr_cnt) begin
      cnt <= 8'd0;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule : ifetch_tmo
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch sequencer. Latches IC/NB on a fetch strobe,
//                issues one memory read, loads IR on acknowledge and pulses
//                cu_ low for one cycle to advance IC. Refusal (or timeout)
//                raises a one-cycle no-memory alarm instead.
//  Config      : IFETCH_TIMEOUT_EN - when defined, a REQ timeout of
//                TMO_CYCLES cycles is added via ifetch_tmo.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch
  import cpu_pkg::*;
#(
  parameter int TMO_CYCLES = IFETCH_TMO_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        clr,
  input  logic        start,
  input  logic        abort,
  input  logic [0:15] ic,
  input  logic [0:3]  nb,
  output logic        mem_req,
  output logic [0:15] mem_ad,
  output logic [0:3]  mem_nb,
  input  logic [0:15] mem_di,
  input  logic        mem_ok,
  input  logic        mem_en,
  output logic [0:15] ir,
  output logic        ir_valid,
  output logic        cu_,
  output logic        busy,
  output logic        alarm_nomem
);

  ifetch_state_t state;
  logic          tmo_expired;

`ifdef IFETCH_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  // Counter restarts on every accepted fetch and runs only while REQ waits
  assign tmo_clr = (state == IDLE) && start;
  assign tmo_en  = (state == REQ) && !mem_ok && !abort && !mem_en;

  ifetch_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk_sys (clk_sys),
    .clr     (clr),
    .clr_cnt (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );
`else
  // Without the timeout REQ can wait forever; the parameter has no effect
  logic unused_tmo;
  assign unused_tmo  = ^8'(TMO_CYCLES);
  assign tmo_expired = 1'b0;
`endif

  // Fetch FSM with all outputs registered; alarm and cu_ default to idle
  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_ad      <= 16'd0;
      mem_nb      <= 4'd0;
      ir          <= 16'd0;
      ir_valid    <= 1'b0;
      cu_         <= 1'b1;
      busy        <= 1'b0;
      alarm_nomem <= 1'b0;
    end else begin
      alarm_nomem <= 1'b0;
      cu_         <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            mem_ad   <= ic;
            mem_nb   <= nb;
            ir_valid <= 1'b0;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // Acknowledge wins over abort so a completed read is never lost
          if (mem_ok) begin
            ir       <= mem_di;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            cu_      <= 1'b0;
            state    <= INC;
          end else if (abort) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (mem_en || tmo_expired) begin
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            alarm_nomem <= 1'b1;
            state       <= IDLE;
          end
        end
        INC: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule : ifetch
`default_nettype wire
